// File: rtl/scores_stream_buffer.sv
// -----------------------------------------------------------------------------
// scores_stream_buffer
//
// Captures one frame of NUM_CLASSES signed scores per inference into a
// DEPTH-frame ring buffer and streams the oldest frame out as little-endian
// bytes over a valid/ready byte interface (UART TX side). Each frame may be
// preceded by a SYNC_BYTE header byte.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   clear        synchronous flush of ring and stream (also drops a same-cycle write)
//   wr_en        one-cycle pulse: capture scores_flat as a new frame
//   scores_flat  packed scores, class k at [k*SCORE_W +: SCORE_W]
//   out_data     stream byte (held stable while out_valid && !out_ready)
//   out_valid    out_data valid
//   out_ready    consumer accepts byte
//   frame_done   pulses in the cycle the last byte of a frame is handshaken
//   level        frames stored, 0..DEPTH
//   full         level == DEPTH
//   empty        level == 0
//   overflow     sticky: a frame was dropped because the ring was full
// -----------------------------------------------------------------------------
module scores_stream_buffer #(
    parameter int          NUM_CLASSES = 10,
    parameter int          SCORE_W     = 32,
    parameter int          DEPTH       = 4,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    localparam int         BPS         = (SCORE_W + 7) / 8,
    localparam int         FRAME_BYTES = NUM_CLASSES * BPS,
    localparam int         LW          = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           frame_done,
    output logic [LW-1:0]                  level,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(FRAME_BYTES + 1);
    localparam int FW = NUM_CLASSES * SCORE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Sign-extend one score to the full BPS*8-bit emitted width.
    function automatic logic [BPS*8-1:0] sext_score(input logic [SCORE_W-1:0] s);
        logic [BPS*8-1:0] r;
        r = {(BPS*8){s[SCORE_W-1]}};
        r[SCORE_W-1:0] = s;
        return r;
    endfunction

    logic [FW-1:0]   mem_r [DEPTH];
    state_t          state_r;
    state_t          state_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [BW-1:0]   byte_idx_r;
    logic [BW-1:0]   byte_idx_s;
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_s;
    logic            full_r;
    logic            empty_r;
    logic            overflow_r;
    logic            out_valid_r;
    logic [7:0]      out_data_r;
    logic [7:0]      out_data_s;
    logic            hs_s;
    logic            last_hs_s;
    logic            slot_s;
    logic            wr_acc_s;
    logic            drop_s;
    logic [7:0]      frame_bytes_s [FRAME_BYTES];

    // Handshake, final-byte and write-acceptance decode.
    always_comb begin
        hs_s      = out_valid_r & out_ready;
        last_hs_s = (state_r == ST_DATA) & hs_s & (byte_idx_r == BW'(FRAME_BYTES - 1));
        // A full ring still takes a write when the head frame retires this cycle:
        // the retiring slot is exactly the one wr_ptr points at.
        slot_s    = (level_r != LW'(DEPTH)) | last_hs_s;
        wr_acc_s  = wr_en & slot_s;
        drop_s    = wr_en & ~slot_s;
    end

    // Next occupancy: simultaneous accept and retire leave level unchanged.
    always_comb begin
        level_s = level_r;
        case ({wr_acc_s, last_hs_s})
            2'b10:   level_s = level_r + LW'(1);
            2'b01:   level_s = level_r - LW'(1);
            default: level_s = level_r;
        endcase
    end

    // Byte view of the frame at rd_ptr, sign-extended and little-endian per score.
    always_comb begin : frame_bytes_blk
        logic [BPS*8-1:0] ext_v;
        ext_v = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            ext_v = sext_score(mem_r[rd_ptr_r][c*SCORE_W +: SCORE_W]);
            for (int j = 0; j < BPS; j++) begin
                frame_bytes_s[c*BPS + j] = ext_v[j*8 +: 8];
            end
        end
    end

    // Stream FSM next-state and byte index.
    always_comb begin
        state_s    = state_r;
        byte_idx_s = byte_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (level_r != LW'(0)) begin
                    state_s    = HEADER_EN ? ST_HDR : ST_DATA;
                    byte_idx_s = BW'(0);
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hs_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (last_hs_s) begin
                    state_s    = ST_IDLE;
                    byte_idx_s = BW'(0);
                end else if (hs_s) begin
                    byte_idx_s = byte_idx_r + BW'(1);
                end else begin
                    byte_idx_s = byte_idx_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                byte_idx_s = BW'(0);
            end
        endcase
    end

    // Byte to present next cycle; computed from the next state so the output is a register.
    // The rd_ptr slot is never written while its frame is being streamed, so the
    // value stays stable across stalled cycles.
    always_comb begin
        out_data_s = 8'h00;
        case (state_s)
            ST_HDR: begin
                out_data_s = SYNC_BYTE;
            end
            ST_DATA: begin
                for (int b = 0; b < FRAME_BYTES; b++) begin
                    out_data_s = (byte_idx_s == BW'(b)) ? frame_bytes_s[b] : out_data_s;
                end
            end
            default: begin
                out_data_s = 8'h00;
            end
        endcase
    end

    // Control state, pointers, flags and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst | clear) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            byte_idx_r  <= '0;
            level_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else begin
            state_r     <= state_s;
            byte_idx_r  <= byte_idx_s;
            level_r     <= level_s;
            full_r      <= (level_s == LW'(DEPTH));
            empty_r     <= (level_s == LW'(0));
            out_valid_r <= (state_s != ST_IDLE);
            out_data_r  <= out_data_s;
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (last_hs_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Frame storage; contents are don't-care after reset so no reset branch.
    always_ff @(posedge clk) begin
        if (wr_acc_s & ~rst & ~clear) begin
            mem_r[wr_ptr_r] <= scores_flat;
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    // Must coincide with the final handshake itself, so it is decoded from out_ready.
    assign frame_done = last_hs_s;
    assign level      = level_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_scores_stream_buffer.sv
module tb_scores_stream_buffer;

    localparam int NC    = 10;
    localparam int SW    = 32;
    localparam int D     = 4;
    localparam int BPS   = 4;
    localparam int TOTAL = 1 + NC * BPS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (defaults)
    logic             rst, clear, wr_en, out_ready;
    logic [NC*SW-1:0] scores_flat;
    logic [7:0]       out_data;
    logic             out_valid, frame_done, full, empty, overflow;
    logic [2:0]       level;

    // second instance: SCORE_W=20, NUM_CLASSES=2, no header
    logic             clear2, wr2, ready2;
    logic [39:0]      scores2;
    logic [7:0]       data2;
    logic             valid2, fd2, full2, empty2, ovf2;
    logic [2:0]       level2;

    scores_stream_buffer dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .scores_flat(scores_flat),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done), .level(level), .full(full), .empty(empty),
        .overflow(overflow)
    );

    scores_stream_buffer #(.NUM_CLASSES(2), .SCORE_W(20), .HEADER_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clear(clear2), .wr_en(wr2), .scores_flat(scores2),
        .out_data(data2), .out_valid(valid2), .out_ready(ready2),
        .frame_done(fd2), .level(level2), .full(full2), .empty(empty2),
        .overflow(ovf2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected stream byte at position pos of a frame (header first).
    function automatic logic [7:0] exp_byte(input logic [NC*SW-1:0] fr, input int pos);
        int     p;
        int     cls;
        int     j;
        longint v;
        if (pos == 0) return 8'hA5;
        p   = pos - 1;
        cls = p / BPS;
        j   = p % BPS;
        v   = longint'($signed(fr[cls*SW +: SW]));
        return 8'((v >>> (8 * j)) & 64'hFF);
    endfunction

    // behavioural model
    logic [NC*SW-1:0] mq[$];
    bit               m_on  = 1'b0;
    bit               m_act = 1'b0;
    int               m_pos = 0;
    bit               m_ovf = 1'b0;
    int               fd_count = 0;
    logic [7:0]       cap[$];
    logic [7:0]       cap2[$];

    always @(negedge clk) begin
        bit hs;
        bit last;
        bit slot;
        if (m_on) begin
            hs   = m_act && out_ready;
            last = hs && (m_pos == TOTAL - 1);
            chk("out_valid", 64'(out_valid), 64'(m_act));
            if (m_act) chk("out_data", 64'(out_data), 64'(exp_byte(mq[0], m_pos)));
            chk("frame_done", 64'(frame_done), 64'(last));
            chk("level", 64'(level), 64'(mq.size()));
            chk("full", 64'(full), 64'(mq.size() == D));
            chk("empty", 64'(empty), 64'(mq.size() == 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (out_valid && out_ready) cap.push_back(out_data);
            if (frame_done) fd_count++;
            if (rst || clear) begin
                mq.delete();
                m_act = 1'b0;
                m_pos = 0;
                m_ovf = 1'b0;
            end else begin
                slot = (mq.size() < D) || last;
                if (!m_act) begin
                    if (mq.size() != 0) begin
                        m_act = 1'b1;
                        m_pos = 0;
                    end
                end else if (hs) begin
                    if (last) begin
                        void'(mq.pop_front());
                        m_act = 1'b0;
                        m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end
                if (wr_en) begin
                    if (slot) mq.push_back(scores_flat);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (valid2 && ready2) cap2.push_back(data2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [NC*SW-1:0] f);
        wr_en = 1'b1;
        scores_flat = f;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [NC*SW-1:0] mk0();
        logic [NC*SW-1:0] f;
        for (int k = 0; k < NC; k++) f[k*SW +: SW] = (k == 0) ? 32'h12345678 : 32'(k);
        return f;
    endfunction

    function automatic logic [NC*SW-1:0] mkr();
        logic [NC*SW-1:0] f;
        for (int k = 0; k < NC; k++) f[k*SW +: SW] = 32'($urandom());
        return f;
    endfunction

    logic [7:0] ref1[$];
    logic [7:0] e2[6];
    bit         done;

    initial begin
        e2 = '{8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07};
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; scores_flat = '0; out_ready = 1'b1;
        clear2 = 1'b0; wr2 = 1'b0; scores2 = '0; ready2 = 1'b1;
        tick(); tick();
        m_on = 1'b1;
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single frame, always ready
        cap.delete(); fd_count = 0; out_ready = 1'b1;
        wr1(mk0());
        chk("lat_level_n1", 64'(level), 64'd1);
        chk("lat_valid_n1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid_n2", 64'(out_valid), 64'd1);
        repeat (45) tick();
        chk("s1_count", 64'(cap.size()), 64'd41);
        if (cap.size() == 41) begin
            chk("s1_b0", 64'(cap[0]), 64'hA5);
            chk("s1_b1", 64'(cap[1]), 64'h78);
            chk("s1_b2", 64'(cap[2]), 64'h56);
            chk("s1_b3", 64'(cap[3]), 64'h34);
            chk("s1_b4", 64'(cap[4]), 64'h12);
            chk("s1_b5", 64'(cap[5]), 64'h01);
            chk("s1_b6", 64'(cap[6]), 64'h00);
            chk("s1_b37", 64'(cap[37]), 64'h09);
            chk("s1_b40", 64'(cap[40]), 64'h00);
        end
        chk("s1_fd_count", 64'(fd_count), 64'd1);
        chk("s1_level_end", 64'(level), 64'd0);
        ref1 = cap;

        // 2: same frame with random backpressure
        cap.delete();
        wr1(mk0());
        repeat (150) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        repeat (50) tick();
        chk("s2_count", 64'(cap.size()), 64'd41);
        if (cap.size() == 41 && ref1.size() == 41) begin
            for (int i = 0; i < 41; i++) chk("s2_byte", 64'(cap[i]), 64'(ref1[i]));
        end

        // 3: overflow with five writes while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr1(mkr());
        tick();
        chk("s3_level", 64'(level), 64'd4);
        chk("s3_full", 64'(full), 64'd1);
        chk("s3_ovf", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        repeat (4 * 42 + 10) tick();
        chk("s3_empty", 64'(empty), 64'd1);
        chk("s3_ovf_sticky", 64'(overflow), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("s3_ovf_cleared", 64'(overflow), 64'd0);

        // 4: six frames one at a time (pointer wrap)
        for (int i = 0; i < 6; i++) begin
            wr1(mkr());
            repeat (45) tick();
        end

        // 5: full ring, write coincident with final handshake
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr1(mkr());
        tick();
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (m_act && m_pos == TOTAL - 1) begin
                wr_en = 1'b1;
                scores_flat = mkr();
                tick();
                wr_en = 1'b0;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        chk("s5_coincident_found", 64'(done), 64'd1);
        chk("s5_ovf", 64'(overflow), 64'd0);
        chk("s5_level", 64'(level), 64'd4);
        repeat (4 * 42 + 10) tick();
        chk("s5_empty", 64'(empty), 64'd1);

        // 6: random traffic
        repeat (3000) begin
            wr_en = ($urandom_range(0, 15) == 0);
            scores_flat = mkr();
            out_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 399) == 0);
            tick();
        end
        wr_en = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (4 * 42 + 10) tick();

        // 7: narrow instance, sign extension and clear mid-frame
        cap2.delete(); ready2 = 1'b1;
        wr2 = 1'b1; scores2 = {20'h7FFFF, 20'hFFFFB};
        tick();
        wr2 = 1'b0;
        repeat (12) tick();
        chk("n_count", 64'(cap2.size()), 64'd6);
        if (cap2.size() == 6) for (int i = 0; i < 6; i++) chk("n_byte", 64'(cap2[i]), 64'(e2[i]));
        ready2 = 1'b0;
        wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
        repeat (3) tick();
        chk("n_valid_stalled", 64'(valid2), 64'd1);
        ready2 = 1'b1;
        tick(); tick();
        ready2 = 1'b0;
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        chk("n_clear_valid", 64'(valid2), 64'd0);
        chk("n_clear_level", 64'(level2), 64'd0);
        cap2.delete(); ready2 = 1'b1;
        wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
        repeat (12) tick();
        chk("n2_count", 64'(cap2.size()), 64'd6);
        if (cap2.size() == 6) for (int i = 0; i < 6; i++) chk("n2_byte", 64'(cap2[i]), 64'(e2[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
